// File: rtl/fwd_hazard_unit_if.sv
// Bundle between the ID/EX pipeline control and the forwarding/hazard unit.
// The master drives the decoded ID fields; the slave returns the selects and the stall controls.
interface fwd_hazard_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_Rn;
    logic [REG_W-1:0] id_Rm;
    logic             id_useRn;
    logic             id_useRm;
    logic [REG_W-1:0] id_Rd;
    logic             id_RegWrite;
    logic             id_MemRead;
    logic             id_setflags;
    logic             id_readflags;
    logic             flush;
    logic [1:0]       forwardA;
    logic [1:0]       forwardB;
    logic             stall;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_bubble;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_Rn, id_Rm, id_useRn, id_useRm, id_Rd,
               id_RegWrite, id_MemRead, id_setflags, id_readflags, flush,
        input  forwardA, forwardB, stall, pc_write, ifid_write, idex_bubble, stall_count
    );

    modport slave (
        input  id_valid, id_Rn, id_Rm, id_useRn, id_useRm, id_Rd,
               id_RegWrite, id_MemRead, id_setflags, id_readflags, flush,
        output forwardA, forwardB, stall, pc_write, ifid_write, idex_bubble, stall_count
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use / flag-use hazard control for the execute stage.
// Keeps its own Rd/control shadow of the EX and MEM stages; WB needs none (write-first regfile).
module fwd_hazard_unit #(
    parameter int REG_W = 5,
    parameter int XZR   = 31,
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              rst_n,
    fwd_hazard_unit_if.slave hz_if
);
    localparam logic [REG_W-1:0] XZR_IDX = REG_W'(XZR);

    logic             ex_valid_q, ex_regwrite_q, ex_memread_q, ex_setflags_q;
    logic [REG_W-1:0] ex_rd_q;
    logic             mem_valid_q, mem_regwrite_q;
    logic [REG_W-1:0] mem_rd_q;
    logic [1:0]       fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             src_a_ok, src_b_ok;
    logic             load_use, flag_haz, stall, idex_bubble;

    // EX holds the younger producer, so it is checked first; loads in EX cannot forward yet.
    function automatic logic [1:0] fwd_sel(input logic ok, input logic [REG_W-1:0] src);
        if (ok && ex_valid_q && ex_regwrite_q && !ex_memread_q && ex_rd_q == src)
            return 2'b01;
        else if (ok && mem_valid_q && mem_regwrite_q && mem_rd_q == src)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        src_a_ok = hz_if.id_valid && hz_if.id_useRn && (hz_if.id_Rn != XZR_IDX);
        src_b_ok = hz_if.id_valid && hz_if.id_useRm && (hz_if.id_Rm != XZR_IDX);
        fwd_a_d  = fwd_sel(src_a_ok, hz_if.id_Rn);
        fwd_b_d  = fwd_sel(src_b_ok, hz_if.id_Rm);

        load_use = ex_valid_q && ex_memread_q && ex_regwrite_q && (ex_rd_q != XZR_IDX) &&
                   ((src_a_ok && hz_if.id_Rn == ex_rd_q) || (src_b_ok && hz_if.id_Rm == ex_rd_q));
        flag_haz = hz_if.id_valid && hz_if.id_readflags && ex_valid_q && ex_setflags_q;

        // A taken branch kills the ID instruction, so any hazard it had is moot.
        stall       = !hz_if.flush && (load_use || flag_haz);
        idex_bubble = stall || hz_if.flush;

        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            ex_setflags_q  <= 1'b0;
            ex_rd_q        <= '0;
            mem_valid_q    <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_rd_q       <= '0;
            fwd_a_q        <= 2'b00;
            fwd_b_q        <= 2'b00;
            stall_cnt_q    <= '0;
        end else begin
            ex_valid_q     <= hz_if.id_valid && !idex_bubble;
            ex_regwrite_q  <= hz_if.id_RegWrite;
            ex_memread_q   <= hz_if.id_MemRead;
            ex_setflags_q  <= hz_if.id_setflags;
            ex_rd_q        <= hz_if.id_Rd;
            mem_valid_q    <= ex_valid_q;
            mem_regwrite_q <= ex_regwrite_q;
            mem_rd_q       <= ex_rd_q;
            fwd_a_q        <= idex_bubble ? 2'b00 : fwd_a_d;
            fwd_b_q        <= idex_bubble ? 2'b00 : fwd_b_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign hz_if.forwardA    = fwd_a_q;
    assign hz_if.forwardB    = fwd_b_q;
    assign hz_if.stall       = stall;
    assign hz_if.pc_write    = !stall;
    assign hz_if.ifid_write  = !stall;
    assign hz_if.idex_bubble = idex_bubble;
    assign hz_if.stall_count = stall_cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: instruction sequences with forward selects queued at issue and
// compared in the consumer's EX cycle; a second CNT_W=2 instance exercises counter saturation.
module tb_fwd_hazard_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   total  = 0;
    int   passed = 0;
    int   exp_cnt = 0;

    typedef struct {
        string      tag;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.REG_W(5), .CNT_W(16)) hz_if ();
    fwd_hazard_unit_if #(.REG_W(5), .CNT_W(2))  hz2_if ();

    fwd_hazard_unit #(.REG_W(5), .XZR(31), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .hz_if(hz_if));
    fwd_hazard_unit #(.REG_W(5), .XZR(31), .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .hz_if(hz2_if));

    assign hz2_if.id_valid     = hz_if.id_valid;
    assign hz2_if.id_Rn        = hz_if.id_Rn;
    assign hz2_if.id_Rm        = hz_if.id_Rm;
    assign hz2_if.id_useRn     = hz_if.id_useRn;
    assign hz2_if.id_useRm     = hz_if.id_useRm;
    assign hz2_if.id_Rd        = hz_if.id_Rd;
    assign hz2_if.id_RegWrite  = hz_if.id_RegWrite;
    assign hz2_if.id_MemRead   = hz_if.id_MemRead;
    assign hz2_if.id_setflags  = hz_if.id_setflags;
    assign hz2_if.id_readflags = hz_if.id_readflags;
    assign hz2_if.flush        = hz_if.flush;

    task automatic drive(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                         input logic urn, input logic urm, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic sf, input logic rf);
        hz_if.id_valid     = v;
        hz_if.id_Rn        = rn;
        hz_if.id_Rm        = rm;
        hz_if.id_useRn     = urn;
        hz_if.id_useRm     = urm;
        hz_if.id_Rd        = rd;
        hz_if.id_RegWrite  = rw;
        hz_if.id_MemRead   = mr;
        hz_if.id_setflags  = sf;
        hz_if.id_readflags = rf;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        tick();
        tick();
    endtask

    task automatic pop_check();
        exp_t e;
        total++;
        if (sb_q.size() == 0) begin
            $display("FAIL scoreboard_empty: no expected entry queued");
        end else begin
            e = sb_q.pop_front();
            if (hz_if.forwardA !== e.fa || hz_if.forwardB !== e.fb)
                $display("FAIL %s: forwardA/B=%b/%b expected %b/%b",
                         e.tag, hz_if.forwardA, hz_if.forwardB, e.fa, e.fb);
            else
                passed++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hz_if.flush = 1'b0;
        nop();
        #2;
        total++;
        if (hz_if.forwardA !== 2'b00 || hz_if.forwardB !== 2'b00 || hz_if.stall !== 1'b0 ||
            hz_if.pc_write !== 1'b1 || hz_if.ifid_write !== 1'b1 || hz_if.idex_bubble !== 1'b0 ||
            hz_if.stall_count !== 16'd0)
            $display("FAIL reset_state: fa=%b fb=%b stall=%b pcw=%b ifw=%b bub=%b cnt=%0d expected 00 00 0 1 1 0 0",
                     hz_if.forwardA, hz_if.forwardB, hz_if.stall, hz_if.pc_write,
                     hz_if.ifid_write, hz_if.idex_bubble, hz_if.stall_count);
        else passed++;
        hz_if.flush = 1'b1;
        #1;
        total++;
        if (hz_if.idex_bubble !== 1'b1)
            $display("FAIL reset_flush_bubble: idex_bubble=%b expected 1", hz_if.idex_bubble);
        else passed++;
        hz_if.flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);   // ADD X1,X2,X3
        tick();
        drive(1'b1, 5'd1, 5'd3, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);   // SUB X2,X1,X3
        sb_q.push_back('{"b2b_fwd", 2'b01, 2'b00});
        #1;
        total++;
        if (hz_if.stall !== 1'b0) $display("FAIL b2b_stall: stall=%b expected 0", hz_if.stall);
        else passed++;
        tick();
        pop_check();
        drain();
    endtask

    task automatic test_distance2();
        drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);   // ADD X1
        tick();
        nop();
        tick();
        drive(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);   // ORR X4,X1,X1
        sb_q.push_back('{"dist2_fwd", 2'b10, 2'b10});
        tick();
        pop_check();
        drain();
    endtask

    task automatic test_load_use();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);   // LDUR X5,[X0]
        tick();
        drive(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);   // ADD X6,X5,X7
        #1;
        total++;
        if (hz_if.stall !== 1'b1 || hz_if.pc_write !== 1'b0 || hz_if.ifid_write !== 1'b0 ||
            hz_if.idex_bubble !== 1'b1 || hz_if.stall_count !== 16'(exp_cnt))
            $display("FAIL load_use_stall: stall=%b pcw=%b ifw=%b bub=%b cnt=%0d expected 1 0 0 1 %0d",
                     hz_if.stall, hz_if.pc_write, hz_if.ifid_write, hz_if.idex_bubble,
                     hz_if.stall_count, exp_cnt);
        else passed++;
        exp_cnt++;
        sb_q.push_back('{"load_use_bubble", 2'b00, 2'b00});
        tick();
        pop_check();
        total++;
        if (hz_if.stall !== 1'b0 || hz_if.stall_count !== 16'(exp_cnt))
            $display("FAIL load_use_release: stall=%b cnt=%0d expected 0 %0d",
                     hz_if.stall, hz_if.stall_count, exp_cnt);
        else passed++;
        sb_q.push_back('{"load_use_fwd", 2'b10, 2'b00});
        tick();
        pop_check();
        drain();
    endtask

    task automatic test_xzr_priority();
        drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0);  // ADD X31
        tick();
        drive(1'b1, 5'd31, 5'd31, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0); // ADD X8,X31,X31
        sb_q.push_back('{"xzr_fwd", 2'b00, 2'b00});
        tick();
        pop_check();
        drain();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0);  // LDUR X31
        tick();
        drive(1'b1, 5'd31, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        total++;
        if (hz_if.stall !== 1'b0) $display("FAIL xzr_load_stall: stall=%b expected 0", hz_if.stall);
        else passed++;
        drain();
        drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);   // ADD X9
        tick();
        drive(1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);   // ADD X9
        tick();
        drive(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);  // use X9
        sb_q.push_back('{"ex_beats_mem", 2'b01, 2'b01});
        tick();
        pop_check();
        drain();
        drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);  // ADD X11
        tick();
        drive(1'b1, 5'd11, 5'd11, 1'b0, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0); // Rn unused
        sb_q.push_back('{"unused_src", 2'b00, 2'b01});
        tick();
        pop_check();
        drain();
    endtask

    task automatic test_flags();
        drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);  // SUBS
        tick();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);   // bubble with readflags
        #1;
        total++;
        if (hz_if.stall !== 1'b0) $display("FAIL flag_bubble_stall: stall=%b expected 0", hz_if.stall);
        else passed++;
        drain();
        drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);  // SUBS
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);   // B.cond
        #1;
        total++;
        if (hz_if.stall !== 1'b1 || hz_if.idex_bubble !== 1'b1)
            $display("FAIL flag_stall: stall=%b bub=%b expected 1 1", hz_if.stall, hz_if.idex_bubble);
        else passed++;
        exp_cnt++;
        tick();
        total++;
        if (hz_if.stall !== 1'b0 || hz_if.stall_count !== 16'(exp_cnt))
            $display("FAIL flag_release: stall=%b cnt=%0d expected 0 %0d",
                     hz_if.stall, hz_if.stall_count, exp_cnt);
        else passed++;
        drain();
        drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);  // SUBS
        tick();
        drive(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);  // B.cond, flushed
        hz_if.flush = 1'b1;
        #1;
        total++;
        if (hz_if.stall !== 1'b0 || hz_if.idex_bubble !== 1'b1 || hz_if.pc_write !== 1'b1)
            $display("FAIL flush_wins: stall=%b bub=%b pcw=%b expected 0 1 1",
                     hz_if.stall, hz_if.idex_bubble, hz_if.pc_write);
        else passed++;
        sb_q.push_back('{"flush_fwd_zero", 2'b00, 2'b00});
        tick();
        hz_if.flush = 1'b0;
        pop_check();
        drain();
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);   // ADD X1
        tick();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);   // LDUR X5,[X1]
        sb_q.push_back('{"pre_reset_fwd", 2'b01, 2'b00});
        tick();
        pop_check();
        drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        total++;
        if (hz_if.stall !== 1'b1) $display("FAIL pre_reset_stall: stall=%b expected 1", hz_if.stall);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        total++;
        if (hz_if.stall !== 1'b0 || hz_if.forwardA !== 2'b00 || hz_if.forwardB !== 2'b00 ||
            hz_if.stall_count !== 16'd0)
            $display("FAIL async_reset: stall=%b fa=%b fb=%b cnt=%0d expected 0 00 00 0",
                     hz_if.stall, hz_if.forwardA, hz_if.forwardB, hz_if.stall_count);
        else passed++;
        #1;
        rst_n = 1'b1;
        drain();
    endtask

    task automatic test_saturation();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        exp_cnt = 0;
        // Sets and reads flags: stalls on alternate cycles, five stalls in ten cycles.
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            #1;
            total++;
            if (hz_if.stall !== logic'(i % 2) || hz2_if.stall !== logic'(i % 2))
                $display("FAIL sat_stall_%0d: stall=%b/%b expected %0d", i, hz_if.stall, hz2_if.stall, i % 2);
            else passed++;
            if (i % 2 == 1) exp_cnt++;
            tick();
        end
        total++;
        if (hz2_if.stall_count !== 2'd3)
            $display("FAIL sat_count_w2: stall_count=%0d expected 3", hz2_if.stall_count);
        else passed++;
        total++;
        if (hz_if.stall_count !== 16'(exp_cnt))
            $display("FAIL sat_count_w16: stall_count=%0d expected %0d", hz_if.stall_count, exp_cnt);
        else passed++;
        drain();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_distance2();
        test_load_use();
        test_xzr_priority();
        test_flags();
        test_reset_mid_stall();
        test_saturation();
        total++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_leftover: %0d entries expected 0", sb_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
